// File: rtl/full_adder_behav.sv
// Registered behavioural full adder of parameterisable width with a valid tag.
// One-cycle latency; the result registers hold when no qualified sample arrives.
module full_adder_behav #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    // Explicit ripple chain so the carry into every bit is visible on the full WIDTH+1 result.
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
        cout_d = carry[WIDTH];
    end

    // out_valid depends only on in_valid and rst_n, never on the operand values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_behav.sv
// Directed bench for full_adder_behav: a 1-bit and an 8-bit instance share clock and reset.
module tb_full_adder_behav;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       v1, a1, b1, c1;
    logic       s1, co1, ov1;
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic [7:0] s8;
    logic       co8, ov8;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp1_tab [8];
    logic [2:0] vec;
    logic [8:0] exp_wide;

    full_adder_behav #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .out_valid(ov1)
    );

    full_adder_behav #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .cout(co8), .out_valid(ov8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        v1 = v; a1 = a; b1 = b; c1 = c;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        v8 = v; a8 = a; b8 = b; c8 = c;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic s, input logic co, input logic ov);
        check({tag, "_sum1"}, {31'd0, s1}, {31'd0, s});
        check({tag, "_cout1"}, {31'd0, co1}, {31'd0, co});
        check({tag, "_ov1"}, {31'd0, ov1}, {31'd0, ov});
    endtask

    task automatic check8(input string tag, input logic [7:0] s, input logic co, input logic ov);
        check({tag, "_sum8"}, {24'd0, s8}, {24'd0, s});
        check({tag, "_cout8"}, {31'd0, co8}, {31'd0, co});
        check({tag, "_ov8"}, {31'd0, ov8}, {31'd0, ov});
    endtask

    initial begin
        // {cout, sum} indexed by {a, b, cin}
        exp1_tab[0] = 2'b00; exp1_tab[1] = 2'b01; exp1_tab[2] = 2'b01; exp1_tab[3] = 2'b10;
        exp1_tab[4] = 2'b01; exp1_tab[5] = 2'b10; exp1_tab[6] = 2'b10; exp1_tab[7] = 2'b11;

        // Reset held with all-ones operands qualified and the clock running.
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("reset", 1'b0, 1'b0, 1'b0);
            check8("reset", 8'h00, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick();
        check1("post_release_idle", 1'b0, 1'b0, 1'b0);
        check8("post_release_idle", 8'h00, 1'b0, 1'b0);

        // Exhaustive 1-bit, back-to-back.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vec = 3'(i);
            drive1(1'b1, vec[2], vec[1], vec[0]);
            tick();
            check1($sformatf("exh%0d", i), exp1_tab[i][0], exp1_tab[i][1], 1'b1);
        end

        // Hold: results stay, out_valid drops.
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check1("hold_load", 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check1("hold_1", 1'b1, 1'b1, 1'b0);
        tick();
        check1("hold_2", 1'b1, 1'b1, 1'b0);

        // Wide directed vectors.
        @(negedge clk); drive8(1'b1, 8'hFF, 8'h01, 1'b0); tick();
        check8("wide_ff_01", 8'h00, 1'b1, 1'b1);
        @(negedge clk); drive8(1'b1, 8'hFF, 8'hFF, 1'b1); tick();
        check8("wide_ff_ff_1", 8'hFF, 1'b1, 1'b1);
        @(negedge clk); drive8(1'b1, 8'h3C, 8'h05, 1'b1); tick();
        check8("wide_3c_05_1", 8'h42, 1'b0, 1'b1);
        @(negedge clk); drive8(1'b1, 8'h00, 8'h00, 1'b0); tick();
        check8("wide_zero", 8'h00, 1'b0, 1'b1);
        @(negedge clk); drive8(1'b0, 8'hAA, 8'h55, 1'b1); tick();
        check8("wide_hold", 8'h00, 1'b0, 1'b0);

        // Random wide vectors, one per clock period.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            exp_wide = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            tick();
            $display("rand %0d: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", i, a8, b8, c8, s8, co8);
            check8($sformatf("rand%0d", i), exp_wide[7:0], exp_wide[8], 1'b1);
        end

        // Unknown operands with in_valid low must not raise out_valid.
        @(negedge clk);
        drive8(1'b0, 8'hxx, 8'hxx, 1'bx);
        tick();
        check("x_ops_ov8", {31'd0, ov8}, 32'd0);

        // Mid-operation reset: result of edge N discarded, no out_valid pulse.
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b0, 1'b1);
        drive8(1'b1, 8'h12, 8'h34, 1'b0);
        tick();
        check1("midop_edgeN", 1'b0, 1'b1, 1'b1);
        check8("midop_edgeN", 8'h46, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("midop_async", 1'b0, 1'b0, 1'b0);
        check8("midop_async", 8'h00, 1'b0, 1'b0);
        tick();
        check1("midop_edgeN1", 1'b0, 1'b0, 1'b0);
        check8("midop_edgeN1", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b0, 1'b1, 1'b1, 1'b1);
        drive8(1'b0, 8'hFF, 8'hFF, 1'b1);
        tick();
        check1("midop_after", 1'b0, 1'b0, 1'b0);
        check8("midop_after", 8'h00, 1'b0, 1'b0);

        // Recovery after reset.
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        drive8(1'b1, 8'h80, 8'h80, 1'b1);
        tick();
        check1("recover", 1'b0, 1'b1, 1'b1);
        check8("recover", 8'h01, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
